// File: rtl/logic_unit_pkg.sv
// Shared opcode and FSM state types for the slice-serial logic unit.
package logic_unit_pkg;

    typedef enum logic [2:0] {
        OP_AND    = 3'd0,
        OP_OR     = 3'd1,
        OP_XOR    = 3'd2,
        OP_NOR    = 3'd3,
        OP_NAND   = 3'd4,
        OP_XNOR   = 3'd5,
        OP_ANDN   = 3'd6,
        OP_PASS_A = 3'd7
    } logic_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/logic_unit_serial_slice.sv
// Combinational bitwise function over one SLICE-bit chunk of the operands.
module logic_slice
    import logic_unit_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  logic_op_e        op_i,
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    output logic [SLICE-1:0] y_o
);

    always_comb begin
        y_o = '0;
        case (op_i)
            OP_AND:    y_o = a_i & b_i;
            OP_OR:     y_o = a_i | b_i;
            OP_XOR:    y_o = a_i ^ b_i;
            OP_NOR:    y_o = ~(a_i | b_i);
            OP_NAND:   y_o = ~(a_i & b_i);
            OP_XNOR:   y_o = ~(a_i ^ b_i);
            OP_ANDN:   y_o = a_i & ~b_i;
            OP_PASS_A: y_o = a_i;
            default:   y_o = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_serial.sv
// Slice-serial bitwise logic unit: one SLICE per BUSY cycle, LSB first.
// Optional zero flag output enabled by LOGIC_UNIT_ZERO_FLAG_EN.
module logic_unit_serial
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    // valid/ready: a transfer happens on a rising edge where valid and ready are both 1;
    // ready/valid outputs depend only on registered state.
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    output logic             zero,
`endif
    output state_e           dbg_state
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);
    localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SLICE{1'b1}});

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic_op_e        op_q, op_d;
    logic [SLICE-1:0] a_sl, b_sl, y_sl;
    int               base;

    // Shift-based slice access keeps the selects lint-clean for any NSLICE.
    always_comb begin
        base = int'(cnt_q) * SLICE;
        a_sl = SLICE'(a_q >> base);
        b_sl = SLICE'(b_q >> base);
    end

    logic_slice #(.SLICE(SLICE)) u_slice (
        .op_i (op_q),
        .a_i  (a_sl),
        .b_i  (b_sl),
        .y_o  (y_sl)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_BUSY;
                    a_d     = a;
                    b_d     = b;
                    op_d    = logic_op_e'(op);
                    cnt_d   = '0;
                    res_d   = '0;
                end
            end
            ST_BUSY: begin
                res_d = (res_q & ~(SLICE_MASK << base)) | (WIDTH'(y_sl) << base);
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_AND;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
        end
    end

`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    logic zero_q, zero_d;

    always_comb begin
        zero_d = zero_q;
        if (state_q == ST_IDLE && in_valid) zero_d = 1'b1;
        else if (state_q == ST_BUSY)        zero_d = zero_q & (y_sl == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) zero_q <= 1'b1;
        else        zero_q <= zero_d;
    end

    assign zero = zero_q;
`endif

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = res_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_logic_unit_serial.sv
// Directed bench for logic_unit_serial at 32/8 and 16/16 with an expected-result queue.
module tb_logic_unit_serial;
    import logic_unit_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        iv32, ir32, ov32, or32;
    logic [2:0]  op32;
    logic [31:0] a32, b32, r32;
    state_e      st32;

    logic        iv16, ir16, ov16, or16;
    logic [2:0]  op16;
    logic [15:0] a16, b16, r16;
    state_e      st16;

`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    logic z32, z16;
`endif

    logic_unit_serial #(.WIDTH(32), .SLICE(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .op(op32),
        .a(a32), .b(b32), .out_valid(ov32), .out_ready(or32), .result(r32),
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
        .zero(z32),
`endif
        .dbg_state(st32)
    );

    logic_unit_serial #(.WIDTH(16), .SLICE(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .op(op16),
        .a(a16), .b(b16), .out_valid(ov16), .out_ready(or16), .result(r16),
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
        .zero(z16),
`endif
        .dbg_state(st16)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q32[$];
    logic [15:0] exp_q16[$];

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        case (f)
            3'd0:    return x & y;
            3'd1:    return x | y;
            3'd2:    return x ^ y;
            3'd3:    return ~(x | y);
            3'd4:    return ~(x & y);
            3'd5:    return ~(x ^ y);
            3'd6:    return x & ~y;
            default: return x;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic scramble32();
        a32  = $urandom;
        b32  = $urandom;
        op32 = 3'($urandom_range(0, 7));
    endtask

    // Drives one operand set, pushes its expected result at the accept edge,
    // and returns at the negedge right after acceptance.
    task automatic accept32(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op32 = f; a32 = x; b32 = y; iv32 = 1'b1;
        for (int i = 0; i < 20 && !ir32; i++) @(negedge clk);
        check("accept32_ready", 32'(ir32), 32'd1);
        @(posedge clk);
        exp_q32.push_back(model(f, x, y));
        @(negedge clk);
        iv32 = 1'b0;
        scramble32();
    endtask

    task automatic wait_done32();
        int lat = 1;
        while (!ov32 && lat < 50) begin
            check("busy32_in_ready", 32'(ir32), 32'd0);
            @(negedge clk);
            scramble32();
            lat++;
        end
        check("latency32", lat, 32'd5);
    endtask

    task automatic collect32(input int hold);
        logic [31:0] e;
        check("queue32_nonempty", 32'(exp_q32.size() > 0), 32'd1);
        e = (exp_q32.size() > 0) ? exp_q32.pop_front() : 32'hx;
        check("result32", r32, e);
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
        check("zero32", 32'(z32), 32'(e == 32'd0));
`endif
        or32 = 1'b0;
        for (int i = 0; i < hold; i++) begin
            iv32 = 1'b1;
            scramble32();
            @(negedge clk);
            check("hold32_valid", 32'(ov32), 32'd1);
            check("hold32_in_ready", 32'(ir32), 32'd0);
            check("hold32_result", r32, e);
        end
        iv32 = 1'b0;
        or32 = 1'b1;
        @(negedge clk);
        or32 = 1'b0;
        check("release32_valid", 32'(ov32), 32'd0);
        check("release32_in_ready", 32'(ir32), 32'd1);
        check("release32_state", 32'(st32), 32'(ST_IDLE));
        check("release32_result_kept", r32, e);
    endtask

    task automatic run32(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y, input int hold);
        accept32(f, x, y);
        wait_done32();
        collect32(hold);
    endtask

    task automatic run16(input logic [2:0] f, input logic [15:0] x, input logic [15:0] y);
        int lat = 1;
        logic [15:0] e;
        @(negedge clk);
        op16 = f; a16 = x; b16 = y; iv16 = 1'b1;
        for (int i = 0; i < 20 && !ir16; i++) @(negedge clk);
        check("accept16_ready", 32'(ir16), 32'd1);
        @(posedge clk);
        exp_q16.push_back(16'(model(f, 32'(x), 32'(y))));
        @(negedge clk);
        iv16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom);
        while (!ov16 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("latency16", lat, 32'd2);
        e = (exp_q16.size() > 0) ? exp_q16.pop_front() : 16'hx;
        check("result16", 32'(r16), 32'(e));
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
        check("zero16", 32'(z16), 32'(e == 16'd0));
`endif
        or16 = 1'b1;
        @(negedge clk);
        or16 = 1'b0;
        check("release16_in_ready", 32'(ir16), 32'd1);
    endtask

    initial begin
        int acc_cyc[$];
        int got;

        rst_n = 1'b0;
        iv32 = 1'b0; or32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
        iv16 = 1'b0; or16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst32_state", 32'(st32), 32'(ST_IDLE));
        check("rst32_in_ready", 32'(ir32), 32'd1);
        check("rst32_out_valid", 32'(ov32), 32'd0);
        check("rst32_result", r32, 32'd0);
        check("rst16_in_ready", 32'(ir16), 32'd1);
        check("rst16_result", 32'(r16), 32'd0);
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
        check("rst32_zero", 32'(z32), 32'd1);
`endif
        rst_n = 1'b1;

        run32(3'd3, 32'h0000_0000, 32'h0000_0000, 0);
        run32(3'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
        run32(3'd6, 32'hFF00_FF00, 32'h0F0F_0F0F, 3);
        for (int f = 0; f < 8; f++)
            run32(3'(f), $urandom, $urandom, $urandom_range(0, 2));

        // Abort mid-transaction: slice 0 is written, then reset lands on the second BUSY edge.
        accept32(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(negedge clk);
        check("partial32_slice0", r32, 32'h0000_00FF);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort32_state", 32'(st32), 32'(ST_IDLE));
        check("abort32_out_valid", 32'(ov32), 32'd0);
        check("abort32_in_ready", 32'(ir32), 32'd1);
        check("abort32_result", r32, 32'd0);
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
        check("abort32_zero", 32'(z32), 32'd1);
`endif
        void'(exp_q32.pop_front());
        run32(3'd1, 32'h0000_0001, 32'h0000_0002, 0);

        // Back-to-back with out_ready high and in_valid held; operands churn every cycle.
        @(negedge clk);
        or32 = 1'b1;
        iv32 = 1'b1;
        scramble32();
        got = 0;
        for (int c = 0; c < 60 && got < 4; c++) begin
            if (ov32) begin
                check("b2b_result", r32, (exp_q32.size() > 0) ? exp_q32.pop_front() : 32'hx);
                got++;
            end
            if (ir32 && iv32) begin
                exp_q32.push_back(model(op32, a32, b32));
                acc_cyc.push_back(c);
            end
            @(posedge clk);
            #1;
            scramble32();
            if (acc_cyc.size() >= 4) iv32 = 1'b0;
            @(negedge clk);
        end
        iv32 = 1'b0;
        or32 = 1'b0;
        check("b2b_collected", got, 32'd4);
        check("b2b_accepts", acc_cyc.size(), 32'd4);
        for (int i = 1; i < acc_cyc.size(); i++)
            check("b2b_interval", acc_cyc[i] - acc_cyc[i-1], 32'd6);

        run16(3'd4, 16'hFFFF, 16'h00FF);
        run16(3'd5, 16'h1234, 16'h1234);
        run16(3'd6, 16'hA5A5, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic_unit_serial.md
# logic_unit_serial

Parametrised, slice-serial bitwise logic unit and the successor to the fixed 32-bit NOR block in DataPath. It accepts two WIDTH-bit operands and a 3-bit opcode through a valid/ready handshake. It computes one of eight bitwise functions over WIDTH/SLICE cycles and holds the result until the consumer takes it. It sits beside the ALU in the datapath as a low-area logic engine for wide operands.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of SLICE
- SLICE, 8, bits processed per cycle; NSLICE = WIDTH/SLICE ≥ 1
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operand set present
- in_ready  out  1  unit can accept operands
- op  in  3  opcode, sampled on input handshake
- a  in  WIDTH  operand A, sampled on input handshake
- b  in  WIDTH  operand B, sampled on input handshake
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  WIDTH  computed value
- zero  out  1  result == 0; present only with LOGIC_UNIT_ZERO_FLAG_EN

## Operation
- Opcodes: 0 AND, 1 OR, 2 XOR, 3 NOR, 4 NAND, 5 XNOR, 6 ANDN (a & ~b), 7 PASS_A.
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: both 0.
  - DONE: out_valid=1, in_ready=0.
- IDLE → BUSY on in_valid & in_ready. The same edge latches a, b and op, clears slice counter cnt and clears result to 0.
- Each BUSY edge writes result[cnt*SLICE +: SLICE] = f(op, a_slice, b_slice) and increments cnt. Slices go LSB first.
- BUSY → DONE on the edge that processes slice NSLICE-1; cnt wraps to 0.
- DONE → IDLE on out_valid & out_ready.
- result is stable for the whole of DONE and keeps its last value in IDLE until the next accept.
- Operand changes on a/b/op while BUSY or DONE have no effect.
- in_valid is ignored outside IDLE. The unit holds one transaction at a time; there is no overlap.
- Reset (rst_n=0 at an edge) in any state, including mid-BUSY, aborts the transaction. Next cycle: state IDLE, cnt 0, result 0, out_valid 0, in_ready 1, zero 1.

## Timing
- Accept at edge E. Result slices are written at edges E+1 … E+NSLICE. out_valid rises after edge E+NSLICE.
- Latency is NSLICE+1 edges from accept to out_valid (5 at default parameters). Degenerate SLICE=WIDTH gives 2.
- Earliest next accept: the edge after the output handshake. Throughput is one result per NSLICE+2 cycles with out_ready held high.
- in_ready and out_valid are decoded from registered state only. Neither is combinational from in_valid or out_ready.

## Configuration
- LOGIC_UNIT_ZERO_FLAG_EN defined:
  - zero port exists, backed by a zero register.
  - The zero register is set to 1 at accept and ANDed with (slice == 0) on each BUSY edge.
  - zero is valid during DONE and holds until the next accept.
- Undefined: no zero port and no flag logic.

## Structure
- Package logic_unit_pkg:
  - typedef enum logic [2:0] logic_op_e (OP_AND … OP_PASS_A)
  - state typedef (ST_IDLE, ST_BUSY, ST_DONE)
- Sub-module logic_slice: combinational, parameter SLICE, inputs op/a/b slices, output slice result.
- Top holds the FSM, counter, operand registers, result register and optional zero flag.

## Test plan
- WIDTH=32, SLICE=8: op=NOR, a=0x0000_0000, b=0x0000_0000, accepted at edge 0 -> out_valid after edge 4, result=0xFFFF_FFFF, zero=0.
- op=XOR, a=b=0xDEAD_BEEF -> result=0x0000_0000, zero=1 with the macro on. op=ANDN, a=0xFF00_FF00, b=0x0F0F_0F0F -> 0xF000_F000.
- Back-pressure: out_ready low 3 cycles in DONE -> result and out_valid held, in_ready=0, in_valid pulses ignored. Release -> IDLE next cycle, in_ready=1.
- Reset mid-op: rst_n low at edge 2 of BUSY -> next cycle state IDLE, out_valid=0, result=0. A new transaction (op=OR, a=0x1, b=0x2) then returns 0x0000_0003.
- WIDTH=16, SLICE=16: op=NAND, a=0xFFFF, b=0x00FF -> out_valid after edge 1, result=0xFF00.
- Back-to-back with out_ready tied 1: transactions are accepted every 6 cycles. Operands changed while BUSY do not affect the in-flight result.
